// File: rtl/uart_pkg.sv
// uart_pkg: transmitter state encoding and baud divider helper.
// Define UART_TX_PARITY_EN to add the PARITY state.
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } tx_state_t;
  function automatic int calc_div(input int clk, input int baud);
    return clk / baud;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with full/empty flags and a dropped-write pulse.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             drop_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic drop_q, push, pop;
  // Count never exceeds DEPTH, a power of two, so its MSB alone means full.
  assign full_o = cnt_q[AW];
  assign empty_o = cnt_q == '0;
  assign drop_o = drop_q;
  assign push = push_i && !full_o;
  assign pop = pop_i && !empty_o;
  assign data_o = mem_q[rd_q];
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= data_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      drop_q <= 1'b0;
    end else begin
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      drop_q <= push_i && full_o;
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, start/data/stop frames on o_tx.
// Define UART_TX_PARITY_EN to send an even parity bit after the data bits.
module uart_tx_fifo import uart_pkg::*; #(
  parameter int CLK_SPEED  = 100_000_000,
  parameter int BAUDRATE   = 921600,
  parameter int D_BITS     = 8,
  parameter int SP_BITS    = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [D_BITS-1:0] i_data,
  input  logic              i_wr_en,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_overflow,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_tx_done
);
  localparam int DIV = calc_div(CLK_SPEED, BAUDRATE);
  localparam int BW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int CW = D_BITS > 1 ? $clog2(D_BITS) : 1;
`ifdef UART_TX_PARITY_EN
  localparam tx_state_t AFTER_DATA = PARITY;
`else
  localparam tx_state_t AFTER_DATA = STOP;
`endif
  tx_state_t state_q, state_d;
  logic [BW-1:0] baud_q;
  logic [CW-1:0] bit_q;
  logic [D_BITS-1:0] data_q, fifo_data;
  logic tx_q, busy_q, done_q, tx_d, pop, baud_last, data_last, stop_last;
  sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(D_BITS)) u_fifo (
    .clk_i(i_clk),
    .rst_i(i_rst),
    .push_i(i_wr_en),
    .pop_i(pop),
    .data_i(i_data),
    .data_o(fifo_data),
    .full_o(o_full),
    .empty_o(o_empty),
    .drop_o(o_overflow)
  );
  assign baud_last = baud_q == BW'(DIV - 1);
  assign data_last = baud_last && bit_q == CW'(D_BITS - 1);
  // bit_q doubles as the stop-bit counter so SP_BITS*DIV fits a DIV-sized baud counter.
  assign stop_last = state_q == STOP && baud_last && bit_q == CW'(SP_BITS - 1);
  assign pop = !o_empty && (state_q == IDLE || stop_last);
  assign o_tx = tx_q;
  assign o_busy = busy_q;
  assign o_tx_done = done_q;
  always_comb begin
    state_d = state_q;
    tx_d = 1'b1;
    case (state_q)
      IDLE: state_d = o_empty ? IDLE : START;
      START: begin
        tx_d = 1'b0;
        state_d = baud_last ? DATA : START;
      end
      DATA: begin
        tx_d = data_q[bit_q];
        state_d = data_last ? AFTER_DATA : DATA;
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_d = ^data_q;
        state_d = baud_last ? STOP : PARITY;
      end
`endif
      STOP: state_d = stop_last ? (o_empty ? IDLE : START) : STOP;
      default: state_d = IDLE;
    endcase
  end
  // Line outputs are registered from the current state, so they trail the FSM by one clock.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      baud_q <= '0;
      bit_q <= '0;
      data_q <= '0;
      tx_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q <= tx_d;
      busy_q <= state_q != IDLE;
      done_q <= stop_last;
      if (pop) data_q <= fifo_data;
      baud_q <= (state_d != state_q || baud_last) ? '0 : baud_q + 1'b1;
      bit_q <= (state_d != state_q) ? '0 : bit_q + CW'(baud_last);
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: vector table, corner sequences and random traffic against a frame-level model.
module tb_uart_tx_fifo #(parameter int SP = 1);
  localparam int DIV = 16;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int F = DIV * (1 + 8 + P + SP);
  typedef struct {
    logic r;
    logic w;
    logic [7:0] d;
    int adv;
    logic [3:0] e;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, wr = 1'b0;
  logic [7:0] din = '0;
  logic full, empty, ovf, tx, busy, done;
  int checks = 0, errors = 0, busy_cnt = 0, done_cnt = 0, ovf_cnt = 0;
  logic [7:0] q[$];
  int e_n = 0, free_at = 0, fr_start = -100000;
  logic [7:0] fr_b = '0;
  logic [5:0] exp_o = 6'b100001;
  vec_t tbl[$];
  uart_tx_fifo #(
    .CLK_SPEED(1_600_000), .BAUDRATE(100_000), .D_BITS(8), .SP_BITS(SP), .FIFO_DEPTH(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_data(din), .i_wr_en(wr), .o_full(full), .o_empty(empty),
    .o_overflow(ovf), .o_tx(tx), .o_busy(busy), .o_tx_done(done)
  );
  always #5 clk = ~clk;
  function automatic logic bit_at(logic [7:0] b, int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (P != 0 && k == 9) return ^b;
    return 1'b1;
  endfunction
  // Model: a byte queue plus the frame currently on the line; a frame starts the clock after its pop.
  task automatic model(input logic r, input logic w, input logic [7:0] d);
    int t;
    logic a, m_ovf;
    e_n++;
    if (r) begin
      q.delete();
      free_at = e_n + 1;
      fr_start = -100000;
      exp_o = 6'b100001;
      return;
    end
    t = e_n - fr_start;
    a = t >= 0 && t < F;
    m_ovf = w && q.size() == 16;
    exp_o[5:3] = {a ? bit_at(fr_b, t / DIV) : 1'b1, a, a && t == F - 1};
    exp_o[2] = m_ovf;
    if (e_n >= free_at && q.size() > 0) begin
      fr_b = q.pop_front();
      fr_start = e_n + 1;
      free_at = e_n + F;
    end
    if (w && !m_ovf) q.push_back(d);
    exp_o[1:0] = {q.size() == 16, q.size() == 0};
  endtask
  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %b want %b at %0t", nm, act, want, $time);
    end
  endtask
  task automatic chk_int(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, act, want);
    end
  endtask
  task automatic step(input logic r, input logic w, input logic [7:0] d);
    rst = r;
    wr = w;
    din = d;
    @(posedge clk);
    model(r, w, d);
    @(negedge clk);
    chk("model", {tx, busy, done, ovf, full, empty}, exp_o);
    busy_cnt += int'(busy);
    done_cnt += int'(done);
    ovf_cnt += int'(ovf);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask
  task automatic probe(input string nm, input logic [7:0] b, input logic second, input int off,
                       input logic want_tx);
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, b);
    if (second) step(1'b0, 1'b1, 8'h55);
    else step(1'b0, 1'b0, 8'h00);
    idle(off + 1);
    chk(nm, {5'b0, tx}, {5'b0, want_tx});
  endtask
  initial begin
    vec_t v;
    logic [7:0] a5;
    a5 = 8'hA5;
    v = '{r: 1'b1, w: 1'b0, d: 8'h00, adv: 0, e: 4'b1001}; tbl.push_back(v);
    v = '{r: 1'b0, w: 1'b1, d: a5, adv: 0, e: 4'b1000}; tbl.push_back(v);
    v = '{r: 1'b0, w: 1'b0, d: 8'h00, adv: 0, e: 4'b1001}; tbl.push_back(v);
    v = '{r: 1'b0, w: 1'b0, d: 8'h00, adv: 0, e: 4'b0101}; tbl.push_back(v);
    v = '{r: 1'b0, w: 1'b0, d: 8'h00, adv: 14, e: 4'b0101}; tbl.push_back(v);
    for (int i = 0; i < 8; i++) begin
      v = '{r: 1'b0, w: 1'b0, d: 8'h00, adv: (i == 0) ? 0 : 15, e: {a5[i], 3'b101}};
      tbl.push_back(v);
    end
    v = '{r: 1'b0, w: 1'b0, d: 8'h00, adv: 15, e: {(P != 0) ? 1'b0 : 1'b1, 3'b101}}; tbl.push_back(v);
    v = '{r: 1'b0, w: 1'b0, d: 8'h00, adv: F - 146, e: 4'b1111}; tbl.push_back(v);
    v = '{r: 1'b0, w: 1'b0, d: 8'h00, adv: 0, e: 4'b1001}; tbl.push_back(v);
    @(negedge clk);
    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].w, tbl[i].d);
      idle(tbl[i].adv);
      chk($sformatf("tbl%0d", i), {2'b0, tx, busy, done, empty}, {2'b0, tbl[i].e});
    end
`ifdef UART_TX_PARITY_EN
    probe("par07", 8'h07, 1'b0, 16 * 9, 1'b1);
    probe("par03", 8'h03, 1'b0, 16 * 9, 1'b0);
`endif
    probe("stop_first", 8'h00, 1'b0, F - 16 * SP, 1'b1);
    probe("stop_last", 8'h00, 1'b0, F - 1, 1'b1);
    probe("b2b_start", 8'hFF, 1'b1, F, 1'b0);
    probe("idle_after", 8'h00, 1'b0, F, 1'b1);
    step(1'b1, 1'b0, 8'h00);
    busy_cnt = 0;
    done_cnt = 0;
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'h3C);
    idle(3 * F + 20);
    chk_int("burst_busy", busy_cnt, 3 * F);
    chk_int("burst_done", done_cnt, 3);
    step(1'b1, 1'b0, 8'h00);
    ovf_cnt = 0;
    for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'(i));
    chk("full17", {5'b0, full}, 6'd1);
    step(1'b0, 1'b1, 8'h77);
    chk("ovf_pulse", {5'b0, ovf}, 6'd1);
    idle(17 * F + 10);
    chk_int("ovf_count", ovf_cnt, 1);
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'hC3 ^ 8'(i));
    idle(83);
    step(1'b1, 1'b0, 8'h00);
    chk("mid_rst", {2'b0, tx, busy, done, empty}, 6'b001001);
    busy_cnt = 0;
    done_cnt = 0;
    idle(200);
    chk_int("rst_done", done_cnt, 0);
    chk_int("rst_busy", busy_cnt, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 599) == 0, $urandom_range(0, 199) < ((i < 1500) ? 1 : 40), 8'($urandom));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
